// File: rtl/sdc_cmd_seq.sv
// SD command sequencer: turns one command request into the ordered sdc_controller register
// writes, polls command status until done/error/timeout, and passes the host bus through when idle.
module sdc_cmd_seq #(
    parameter logic [6:0] STS_ADDR    = 7'h0C,
    parameter int         DONE_BIT    = 0,
    parameter int         ERR_BIT     = 1,
    parameter int         RD_LAT      = 1,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_cmd,
    input  logic [31:0] req_arg,
    input  logic [7:0]  req_setting,
    input  logic        req_xfer,
    input  logic [11:0] req_blksize,
    input  logic [7:0]  req_blkcnt,
    output logic        done,
    output logic        err,
    output logic        timeout,
    output logic [7:0]  status,
    input  logic [6:0]  host_addr,
    input  logic        host_we,
    input  logic [7:0]  host_data,
    output logic        host_drop,
    output logic [6:0]  sd_addr,
    output logic        sd_we,
    output logic [7:0]  sd_data_o,
    input  logic [7:0]  sd_data_i
);

    localparam logic [1:0]  RD_LAT_C = 2'(RD_LAT);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE,
        WR_BSL,
        WR_BSH,
        WR_BCNT,
        WR_CMD,
        WR_SET,
        WR_A3,
        WR_A2,
        WR_A1,
        WR_A0,
        POLL,
        CLR,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [5:0]  cmd_q;
    logic [31:0] arg_q;
    logic [7:0]  setting_q;
    logic [11:0] blksize_q;
    logic [7:0]  blkcnt_q;
    logic [1:0]  rd_cnt;
    logic [15:0] tmo_cnt;
    logic [7:0]  sample_q;
    logic        err_q;
    logic        tmo_q;

    logic        poll_sample;
    logic        comp_hit;
    logic        poll_expire;

    // A status read is valid RD_LAT cycles after the address is presented.
    assign poll_sample = (state == POLL) && (rd_cnt == RD_LAT_C);
    assign comp_hit    = poll_sample && (sd_data_i[ERR_BIT] || sd_data_i[DONE_BIT]);
    assign poll_expire = (state == POLL) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_xfer ? WR_BSL : WR_CMD;
            WR_BSL:  state_nxt = WR_BSH;
            WR_BSH:  state_nxt = WR_BCNT;
            WR_BCNT: state_nxt = WR_CMD;
            WR_CMD:  state_nxt = WR_SET;
            WR_SET:  state_nxt = WR_A3;
            WR_A3:   state_nxt = WR_A2;
            WR_A2:   state_nxt = WR_A1;
            WR_A1:   state_nxt = WR_A0;
            WR_A0:   state_nxt = POLL;
            POLL:    if (comp_hit || poll_expire) state_nxt = CLR;
            CLR:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sd_addr   = STS_ADDR;
        sd_we     = 1'b0;
        sd_data_o = 8'h00;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                sd_addr   = host_addr;
                sd_we     = host_we;
                sd_data_o = host_data;
                req_ready = 1'b1;
            end
            WR_BSL: begin
                sd_addr   = 7'h44;
                sd_we     = 1'b1;
                sd_data_o = blksize_q[7:0];
            end
            WR_BSH: begin
                sd_addr   = 7'h45;
                sd_we     = 1'b1;
                sd_data_o = {4'h0, blksize_q[11:8]};
            end
            WR_BCNT: begin
                sd_addr   = 7'h48;
                sd_we     = 1'b1;
                sd_data_o = blkcnt_q;
            end
            WR_CMD: begin
                sd_addr   = 7'h05;
                sd_we     = 1'b1;
                sd_data_o = {2'b00, cmd_q};
            end
            WR_SET: begin
                sd_addr   = 7'h04;
                sd_we     = 1'b1;
                sd_data_o = setting_q;
            end
            WR_A3: begin
                sd_addr   = 7'h03;
                sd_we     = 1'b1;
                sd_data_o = arg_q[31:24];
            end
            WR_A2: begin
                sd_addr   = 7'h02;
                sd_we     = 1'b1;
                sd_data_o = arg_q[23:16];
            end
            WR_A1: begin
                sd_addr   = 7'h01;
                sd_we     = 1'b1;
                sd_data_o = arg_q[15:8];
            end
            WR_A0: begin
                sd_addr   = 7'h00;
                sd_we     = 1'b1;
                sd_data_o = arg_q[7:0];
            end
            CLR: begin
                sd_we     = 1'b1;
            end
            DONE: begin
                done      = 1'b1;
                err       = err_q;
                timeout   = tmo_q;
            end
            default: ;
        endcase
    end

    // Request capture, poll counters and result bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q     <= '0;
            arg_q     <= '0;
            setting_q <= '0;
            blksize_q <= '0;
            blkcnt_q  <= '0;
            rd_cnt    <= '0;
            tmo_cnt   <= '0;
            sample_q  <= '0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            status    <= '0;
            host_drop <= 1'b0;
        end else begin
            host_drop <= (state != IDLE) && host_we;

            if (state == IDLE && req_valid) begin
                cmd_q     <= req_cmd;
                arg_q     <= req_arg;
                setting_q <= req_setting;
                blksize_q <= req_blksize;
                blkcnt_q  <= req_blkcnt;
            end

            if (state != POLL) begin
                rd_cnt  <= '0;
                tmo_cnt <= '0;
            end else begin
                rd_cnt  <= poll_sample ? 2'd0 : rd_cnt + 2'd1;
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            if (poll_sample) begin
                sample_q <= sd_data_i;
            end

            // A real completion seen on the final poll cycle wins over the timeout.
            if (state == POLL && (comp_hit || poll_expire)) begin
                err_q <= comp_hit ? sd_data_i[ERR_BIT] : 1'b1;
                tmo_q <= !comp_hit;
            end

            if (state == CLR) begin
                status <= sample_q;
            end
        end
    end

endmodule

// File: tb/tb_sdc_cmd_seq.sv
// Self-checking bench for sdc_cmd_seq: a small sdc_controller status responder plus a
// per-cycle expectation queue built from the command rules, checked on every falling edge.
module tb_sdc_cmd_seq;

    localparam logic [6:0] STS    = 7'h0C;
    localparam int         TMO    = 64;
    localparam int         RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_cmd;
    logic [31:0] req_arg;
    logic [7:0]  req_setting;
    logic        req_xfer;
    logic [11:0] req_blksize;
    logic [7:0]  req_blkcnt;
    logic        done;
    logic        err;
    logic        timeout;
    logic [7:0]  status;
    logic [6:0]  host_addr;
    logic        host_we;
    logic [7:0]  host_data;
    logic        host_drop;
    logic [6:0]  sd_addr;
    logic        sd_we;
    logic [7:0]  sd_data_o;
    logic [7:0]  sd_data_i = 8'h00;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        bit         busy;
        bit         we;
        bit         chk_addr;
        logic [6:0] addr;
        logic [7:0] data;
        bit         done;
        bit         err;
        bit         tmo;
        logic [7:0] sts;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [14:0] wr_log[$];
    logic [7:0]  exp_status = 8'h00;
    bit          drop_pend = 1'b0;
    bit          chk_en = 1'b0;
    int          drop_cnt = 0;
    int          done_cnt = 0;

    logic [15:0] read_cnt = 16'd0;
    logic [7:0]  core_final = 8'h00;
    int          core_ra = 1;

    sdc_cmd_seq #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_arg(req_arg),
        .req_setting(req_setting), .req_xfer(req_xfer), .req_blksize(req_blksize),
        .req_blkcnt(req_blkcnt), .done(done), .err(err), .timeout(timeout), .status(status),
        .host_addr(host_addr), .host_we(host_we), .host_data(host_data), .host_drop(host_drop),
        .sd_addr(sd_addr), .sd_we(sd_we), .sd_data_o(sd_data_o), .sd_data_i(sd_data_i)
    );

    always #5 clk = ~clk;

    // Status register reads as core_final once core_ra status reads have been issued since trigger.
    always @(posedge clk) begin
        if (sd_we && sd_addr == 7'h00) begin
            read_cnt  <= 16'd0;
            sd_data_i <= 8'h00;
        end else if (!sd_we && sd_addr == STS) begin
            read_cnt  <= read_cnt + 16'd1;
            sd_data_i <= (int'(read_cnt) + 1 >= core_ra) ? core_final : 8'h00;
        end else begin
            sd_data_i <= 8'hA5;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_wr(input logic [6:0] addr, input logic [7:0] data);
        exp_t e;
        e = '{default: '0};
        e.busy = 1'b1;
        e.we = 1'b1;
        e.chk_addr = 1'b1;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    function automatic void push_expected(input logic [5:0] cmd, input logic [31:0] arg,
                                          input logic [7:0] set, input logic xfer,
                                          input logic [11:0] bs, input logic [7:0] bc);
        exp_t        e;
        int          p;
        bit          to;
        logic [7:0]  last;
        logic [11:0] bsv;
        logic [31:0] av;
        bsv = bs;
        av = arg;
        e = '{default: '0};
        exp_q.push_back(e);
        if (xfer) begin
            push_wr(7'h44, bsv[7:0]);
            push_wr(7'h45, {4'h0, bsv[11:8]});
            push_wr(7'h48, bc);
        end
        push_wr(7'h05, {2'b00, cmd});
        push_wr(7'h04, set);
        push_wr(7'h03, av[31:24]);
        push_wr(7'h02, av[23:16]);
        push_wr(7'h01, av[15:8]);
        push_wr(7'h00, av[7:0]);
        // Poll cycle c samples every RD_LAT+1 cycles; the value reflects c-1 prior reads.
        p = 0;
        to = 1'b0;
        last = 8'h00;
        for (int c = 1; c <= TMO; c++) begin
            if (c % (RD_LAT + 1) == 0) begin
                last = (c - 1 >= core_ra) ? core_final : 8'h00;
                if (last[1] || last[0]) begin
                    p = c;
                    break;
                end
            end
            if (c == TMO) begin
                p = c;
                to = 1'b1;
            end
        end
        for (int i = 0; i < p; i++) begin
            e = '{default: '0};
            e.busy = 1'b1;
            e.chk_addr = 1'b1;
            e.addr = STS;
            exp_q.push_back(e);
        end
        push_wr(STS, 8'h00);
        e = '{default: '0};
        e.busy = 1'b1;
        e.done = 1'b1;
        e.err = to | last[1];
        e.tmo = to;
        e.sts = last;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = '{default: '0};
            if (!cur.busy) begin
                checkOutput("idle_we", sd_we, host_we);
                checkOutput("idle_addr", sd_addr, host_addr);
                checkOutput("idle_data", sd_data_o, host_data);
                checkOutput("idle_ready", req_ready, 1);
            end else begin
                checkOutput("busy_we", sd_we, cur.we);
                checkOutput("busy_ready", req_ready, 0);
                if (cur.chk_addr) checkOutput("busy_addr", sd_addr, cur.addr);
                if (cur.we) begin
                    checkOutput("busy_data", sd_data_o, cur.data);
                    wr_log.push_back({sd_addr, sd_data_o});
                end
            end
            checkOutput("done", done, cur.done);
            checkOutput("err", err, cur.err);
            checkOutput("timeout", timeout, cur.tmo);
            if (cur.done) exp_status = cur.sts;
            checkOutput("status", status, exp_status);
            checkOutput("host_drop", host_drop, drop_pend);
            if (host_drop) drop_cnt++;
            drop_pend = cur.busy && host_we;
        end
    end

    task automatic applyStimulus(input logic [5:0] cmd, input logic [31:0] arg, input logic [7:0] set,
                                 input logic xfer, input logic [11:0] bs, input logic [7:0] bc);
        @(posedge clk);
        #1;
        req_cmd = cmd;
        req_arg = arg;
        req_setting = set;
        req_xfer = xfer;
        req_blksize = bs;
        req_blkcnt = bc;
        req_valid = 1'b1;
        push_expected(cmd, arg, set, xfer, bs, bc);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output logic e, output logic t, output logic [7:0] s);
        cycles = 0;
        e = 1'b0;
        t = 1'b0;
        s = 8'h00;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done) begin
                cycles = n;
                e = err;
                t = timeout;
                s = status;
                return;
            end
        end
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL wait_done: no done within 200 cycles, expected a done pulse");
    endtask

    int         ncyc;
    logic       r_err;
    logic       r_tmo;
    logic [7:0] r_sts;
    int         dc0;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_cmd = '0;
        req_arg = '0;
        req_setting = '0;
        req_xfer = 1'b0;
        req_blksize = '0;
        req_blkcnt = '0;
        host_addr = '0;
        host_we = 1'b0;
        host_data = '0;

        @(negedge clk);
        checkOutput("rst_ready", req_ready, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_status", status, 0);
        checkOutput("rst_drop", host_drop, 0);
        checkOutput("rst_sd_we", sd_we, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] test 1: all-zero command");
        core_final = 8'h01;
        core_ra = 5;
        wr_log.delete();
        applyStimulus(6'd0, 32'h0, 8'h00, 1'b0, 12'h0, 8'h00);
        waitDone(ncyc, r_err, r_tmo, r_sts);
        checkOutput("t1_cycles", ncyc, 14);
        checkOutput("t1_err", r_err, 0);
        checkOutput("t1_status", r_sts, 8'h01);
        checkOutput("t1_nwrites", wr_log.size(), 7);

        $display("[TB] test 2: cmd 7 argument byte ordering");
        core_final = 8'h01;
        core_ra = 1;
        wr_log.delete();
        applyStimulus(6'd7, 32'h0013_0000, 8'h00, 1'b0, 12'h0, 8'h00);
        waitDone(ncyc, r_err, r_tmo, r_sts);
        checkOutput("t2_cycles", ncyc, 10);
        checkOutput("t2_a2_write", wr_log[3], {7'h02, 8'h13});
        checkOutput("t2_err", r_err, 0);

        $display("[TB] test 3: transfer command with core error");
        core_final = 8'h03;
        core_ra = 3;
        wr_log.delete();
        applyStimulus(6'd17, 32'h0, 8'h5D, 1'b1, 12'h1FF, 8'h00);
        waitDone(ncyc, r_err, r_tmo, r_sts);
        checkOutput("t3_cycles", ncyc, 15);
        checkOutput("t3_bsl", wr_log[0], {7'h44, 8'hFF});
        checkOutput("t3_bsh", wr_log[1], {7'h45, 8'h01});
        checkOutput("t3_cmd", wr_log[3], {7'h05, 8'd17});
        checkOutput("t3_err", r_err, 1);
        checkOutput("t3_tmo", r_tmo, 0);
        checkOutput("t3_status", r_sts, 8'h03);

        $display("[TB] test 4: status stuck, sequencer timeout");
        core_final = 8'h00;
        core_ra = 1;
        applyStimulus(6'd13, 32'h0, 8'h00, 1'b0, 12'h0, 8'h00);
        waitDone(ncyc, r_err, r_tmo, r_sts);
        checkOutput("t4_cycles", ncyc, 72);
        checkOutput("t4_err", r_err, 1);
        checkOutput("t4_tmo", r_tmo, 1);
        checkOutput("t4_status", r_sts, 8'h00);

        $display("[TB] test 5: host pass-through and drop");
        @(posedge clk);
        #1;
        host_addr = 7'h24;
        host_data = 8'h02;
        host_we = 1'b1;
        @(negedge clk);
        checkOutput("t5_fwd_we", sd_we, 1);
        checkOutput("t5_fwd_addr", sd_addr, 7'h24);
        checkOutput("t5_fwd_data", sd_data_o, 8'h02);
        @(posedge clk);
        #1;
        host_we = 1'b0;
        host_addr = 7'h00;
        host_data = 8'h00;
        core_final = 8'h01;
        core_ra = 1;
        drop_cnt = 0;
        wr_log.delete();
        applyStimulus(6'd1, 32'h0, 8'h00, 1'b0, 12'h0, 8'h00);
        host_addr = 7'h30;
        host_data = 8'h77;
        host_we = 1'b1;
        @(posedge clk);
        #1;
        host_we = 1'b0;
        host_addr = 7'h00;
        host_data = 8'h00;
        waitDone(ncyc, r_err, r_tmo, r_sts);
        checkOutput("t5_drop_cnt", drop_cnt, 1);
        checkOutput("t5_cmd_write", wr_log[0], {7'h05, 8'h01});
        checkOutput("t5_set_write", wr_log[1], {7'h04, 8'h00});

        $display("[TB] test 6: reset during argument writes");
        core_final = 8'h01;
        core_ra = 1;
        applyStimulus(6'd2, 32'hDEAD_BEEF, 8'h11, 1'b0, 12'h0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_a2_addr", sd_addr, 7'h02);
        checkOutput("t6_a2_data", sd_data_o, 8'hAD);
        dc0 = done_cnt;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_we", sd_we, 0);
        checkOutput("t6_rst_ready", req_ready, 1);
        checkOutput("t6_rst_done", done, 0);
        exp_q.delete();
        exp_status = 8'h00;
        drop_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t6_no_done", done_cnt, dc0);
        checkOutput("t6_status", status, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
